// File: rtl/music_score_player_if.sv
// Score RAM port: the player (master) drives address, direction and write data;
// the RAM (slave) returns registered key/time one clock after the read address.
interface music_score_player_if #(
  parameter int DataLength  = 4,
  parameter int AddressBits = 5
);
  logic                   read_or_write;
  logic [AddressBits-1:0] address;
  logic [DataLength-1:0]  key_input;
  logic [DataLength-1:0]  time_input;
  logic [DataLength-1:0]  key_output;
  logic [DataLength-1:0]  time_output;

  modport master (
    output read_or_write, address, key_input, time_input,
    input  key_output, time_output
  );

  modport slave (
    input  read_or_write, address, key_input, time_input,
    output key_output, time_output
  );
endinterface

// File: rtl/music_score_player.sv
// Score sequencer: fetches (key,time) entries in address order and holds each key for
// time*TicksPerUnit clocks; 2-clock inter-note gap; host writes pass through only in IDLE.
module music_score_player #(
  parameter int DataLength   = 4,
  parameter int AddressBits  = 5,
  parameter int ScoreLength  = 3,
  parameter int TicksPerUnit = 25000000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_loop,
  input  logic                   i_host_write,
  input  logic [AddressBits-1:0] i_host_address,
  input  logic [DataLength-1:0]  i_host_key,
  input  logic [DataLength-1:0]  i_host_time,
  music_score_player_if.master   ram,
  output logic [DataLength-1:0]  o_current_key,
  output logic                   o_note_valid,
  output logic                   o_note_strobe,
  output logic                   o_playing,
  output logic                   o_done
);

  localparam int TW = $clog2(TicksPerUnit);
  localparam logic [TW-1:0]          TICK_LAST = TW'(TicksPerUnit - 1);
  localparam logic [AddressBits-1:0] ADDR_LAST = AddressBits'(ScoreLength - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_t;

  state_t                 r_state, w_state_nxt;
  logic [AddressBits-1:0] r_address, w_address_nxt;
  logic [DataLength-1:0]  r_current_key, w_key_nxt;
  logic [DataLength-1:0]  r_time, w_time_nxt;
  logic [DataLength-1:0]  r_unit, w_unit_nxt;
  logic [TW-1:0]          r_tick, w_tick_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_end_score;
  logic                   w_host_wr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_address     <= '0;
      r_current_key <= '0;
      r_time        <= '0;
      r_unit        <= '0;
      r_tick        <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_address     <= w_address_nxt;
      r_current_key <= w_key_nxt;
      r_time        <= w_time_nxt;
      r_unit        <= w_unit_nxt;
      r_tick        <= w_tick_nxt;
      r_done        <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_address_nxt = r_address;
    w_key_nxt     = r_current_key;
    w_time_nxt    = r_time;
    w_unit_nxt    = r_unit;
    w_tick_nxt    = r_tick;
    w_done_nxt    = 1'b0;
    w_end_score   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_nxt   = S_FETCH;
          w_address_nxt = '0;
        end
      end
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // A zero duration marks the end of the score.
        if (ram.time_output == '0) begin
          w_end_score = 1'b1;
        end else begin
          w_key_nxt   = ram.key_output;
          w_time_nxt  = ram.time_output;
          w_tick_nxt  = '0;
          w_unit_nxt  = DataLength'(1);
          w_state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        if (r_tick == TICK_LAST) begin
          w_tick_nxt = '0;
          if (r_unit == r_time) begin
            if (r_address < ADDR_LAST) begin
              w_address_nxt = r_address + 1'b1;
              w_state_nxt   = S_FETCH;
            end else begin
              w_end_score = 1'b1;
            end
          end else begin
            w_unit_nxt = r_unit + 1'b1;
          end
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_end_score) begin
      w_address_nxt = '0;
      if (i_loop) begin
        w_state_nxt = S_FETCH;
      end else begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
    end

    // Stop overrides everything, including a note end in the same cycle.
    if (i_stop && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_address_nxt = '0;
      w_done_nxt    = 1'b0;
    end
  end

  assign w_host_wr = (r_state == S_IDLE) && i_host_write && !i_reset;

  assign ram.read_or_write = !w_host_wr;
  assign ram.address       = w_host_wr ? i_host_address : r_address;
  assign ram.key_input     = w_host_wr ? i_host_key : '0;
  assign ram.time_input    = w_host_wr ? i_host_time : '0;

  assign o_current_key = r_current_key;
  assign o_note_valid  = (r_state == S_PLAY);
  assign o_note_strobe = (r_state == S_PLAY) && (r_tick == '0) && (r_unit == DataLength'(1));
  assign o_playing     = (r_state != S_IDLE);
  assign o_done        = r_done;

endmodule

// File: tb/tb_music_score_player.sv
// Directed bench for music_score_player with a registered-read score RAM model.
module tb_music_score_player;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop, hw;
  logic [4:0] ha;
  logic [3:0] hk, ht;
  logic [3:0] key;
  logic       valid, strobe, playing, done;

  int n_chk = 0;
  int n_err = 0;
  int n_wr  = 0;

  logic [3:0] key_mem  [32] = '{default: '0};
  logic [3:0] time_mem [32] = '{default: '0};

  music_score_player_if #(.DataLength(4), .AddressBits(5)) bus ();

  music_score_player #(
    .DataLength(4), .AddressBits(5), .ScoreLength(3), .TicksPerUnit(4)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
    .i_host_write(hw), .i_host_address(ha), .i_host_key(hk), .i_host_time(ht),
    .ram(bus.master),
    .o_current_key(key), .o_note_valid(valid), .o_note_strobe(strobe),
    .o_playing(playing), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus.read_or_write) begin
      key_mem[bus.address]  <= bus.key_input;
      time_mem[bus.address] <= bus.time_input;
      n_wr <= n_wr + 1;
    end
    bus.key_output  <= key_mem[bus.address];
    bus.time_output <= time_mem[bus.address];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [3:0] k, input logic [3:0] t);
    hw = 1'b1; ha = a; hk = k; ht = t;
    tick();
    hw = 1'b0; ha = '0; hk = '0; ht = '0;
  endtask

  // {playing, valid, strobe, done, key[3:0], address[4:0]}
  typedef struct {
    logic        start;
    logic [12:0] exp;
  } vec_t;

  vec_t tab [20];

  initial begin
    int n_str, n_val, n_done, n_play, bad, done_at, key5, wr0;
    logic [4:0] addr19;
    logic       play19;
    logic [3:0] key27;

    tab[0]  = '{1'b1, 13'b0000_0000_00000};
    tab[1]  = '{1'b0, 13'b1000_0000_00000};
    tab[2]  = '{1'b0, 13'b1000_0000_00000};
    tab[3]  = '{1'b0, 13'b1110_0000_00000};
    tab[4]  = '{1'b0, 13'b1100_0000_00000};
    tab[5]  = '{1'b0, 13'b1100_0000_00000};
    tab[6]  = '{1'b0, 13'b1100_0000_00000};
    tab[7]  = '{1'b0, 13'b1000_0000_00001};
    tab[8]  = '{1'b0, 13'b1000_0000_00001};
    tab[9]  = '{1'b0, 13'b1110_0001_00001};
    tab[10] = '{1'b1, 13'b1100_0001_00001};
    tab[11] = '{1'b0, 13'b1100_0001_00001};
    tab[12] = '{1'b0, 13'b1100_0001_00001};
    tab[13] = '{1'b0, 13'b1000_0001_00010};
    tab[14] = '{1'b0, 13'b1000_0001_00010};
    tab[15] = '{1'b0, 13'b1110_0000_00010};
    tab[16] = '{1'b0, 13'b1100_0000_00010};
    tab[17] = '{1'b0, 13'b1100_0000_00010};
    tab[18] = '{1'b0, 13'b1100_0000_00010};
    tab[19] = '{1'b0, 13'b0001_0000_00000};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; hw = 1'b0;
    ha = '0; hk = '0; ht = '0;
    repeat (2) @(posedge clk);
    #1;
    hw = 1'b1; ha = 5'd9; hk = 4'd3; ht = 4'd3;
    @(negedge clk);
    chk("reset_outs", {playing, valid, strobe, done, key}, 8'h00);
    chk("reset_ram_port", {bus.read_or_write, bus.address, bus.key_input, bus.time_input}, 14'h2000);
    tick();
    rst = 1'b0; hw = 1'b0; ha = '0; hk = '0; ht = '0;
    chk("reset_no_write", n_wr, 0);

    // Host load: (key,time) = (0,1),(1,1),(0,1)
    for (int i = 0; i < 3; i++) begin
      hw = 1'b1; ha = 5'(i); hk = (i == 1) ? 4'd1 : 4'd0; ht = 4'd1;
      @(negedge clk);
      chk($sformatf("wr%0d_rw", i), bus.read_or_write, 1'b0);
      chk($sformatf("wr%0d_bus", i), {bus.address, bus.key_input, bus.time_input}, {ha, hk, ht});
      tick();
    end
    hw = 1'b0; ha = 5'd7; hk = 4'd5; ht = 4'd5;
    @(negedge clk);
    chk("idle_rw", bus.read_or_write, 1'b1);
    chk("idle_addr", bus.address, 5'd0);
    tick();
    ha = '0; hk = '0; ht = '0;
    chk("mem_load", {key_mem[0], time_mem[0], key_mem[1], time_mem[1], key_mem[2], time_mem[2]}, 24'h011101);
    chk("wr_count", n_wr, 3);

    // Basic playback, cycle by cycle
    for (int c = 0; c < 20; c++) begin
      start = tab[c].start;
      @(negedge clk);
      chk($sformatf("play_c%0d", c), {playing, valid, strobe, done, key, bus.address}, tab[c].exp);
      tick();
    end
    start = 1'b0;

    // End marker in entry 1
    host_wr(5'd0, 4'd2, 4'd3);
    host_wr(5'd1, 4'd5, 4'd0);
    n_str = 0; n_val = 0; done_at = -1; key5 = 0;
    for (int c = 0; c < 40; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (strobe) n_str++;
      if (valid) n_val++;
      if (valid && key == 4'd5) key5 = 1;
      if (done && done_at < 0) done_at = c;
      tick();
    end
    start = 1'b0;
    chk("marker_strobes", n_str, 1);
    chk("marker_len", n_val, 12);
    chk("marker_done_at", done_at, 17);
    chk("marker_no_key5", key5, 0);

    // Looping playback
    host_wr(5'd0, 4'd0, 4'd1);
    host_wr(5'd1, 4'd1, 4'd1);
    loop = 1'b1;
    n_str = 0; n_done = 0; bad = 0; addr19 = '1; play19 = 1'b0; key27 = '1;
    for (int c = 0; c < 41; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (strobe) begin
        n_str++;
        if ((c - 3) % 6 != 0) bad++;
      end
      if (done) n_done++;
      if (c == 19) begin addr19 = bus.address; play19 = playing; end
      if (c == 27) key27 = key;
      tick();
    end
    start = 1'b0;
    chk("loop_strobes", n_str, 7);
    chk("loop_strobe_period", bad, 0);
    chk("loop_no_done", n_done, 0);
    chk("loop_wrap", {play19, addr19}, 6'b1_00000);
    chk("loop_key27", key27, 4'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0; loop = 1'b0;
    @(negedge clk);
    chk("loop_stop", {playing, valid}, 2'b00);
    tick();

    // Stop on second PLAY cycle, with Start in the same cycle
    n_done = 0; n_play = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0 || c == 4);
      stop  = (c == 4);
      @(negedge clk);
      if (c == 4) chk("stop_pre", {valid, strobe}, 2'b10);
      if (c == 5) chk("stop_next", {playing, valid, bus.address}, 7'd0);
      if (c >= 5) begin
        if (done) n_done++;
        if (playing) n_play++;
      end
      tick();
    end
    start = 1'b0; stop = 1'b0;
    chk("stop_no_done", n_done, 0);
    chk("stop_start_ignored", n_play, 0);

    // Host write during playback must not reach the RAM
    wr0 = n_wr;
    for (int c = 0; c < 20; c++) begin
      start = (c == 0);
      hw = (c == 4); ha = 5'd0; hk = 4'd9; ht = 4'd7;
      @(negedge clk);
      if (c == 4) chk("play_hw_rw", bus.read_or_write, 1'b1);
      if (c == 19) chk("play_hw_done", done, 1'b1);
      tick();
    end
    start = 1'b0; hw = 1'b0; hk = '0; ht = '0;
    chk("play_hw_nowrite", n_wr - wr0, 0);
    chk("play_hw_mem", {key_mem[0], time_mem[0]}, 8'h01);

    // Replay the score, then reset during note 2
    for (int c = 0; c < 12; c++) begin
      start = (c == 0);
      rst = (c == 10);
      hw  = (c == 10); ha = 5'd1; hk = 4'd9; ht = 4'd7;
      @(negedge clk);
      if (c == 3) chk("readback_n1", {valid, strobe, key}, 6'b11_0000);
      if (c == 10) chk("readback_n2", {valid, key}, 5'b1_0001);
      if (c == 11) begin
        chk("rst_mid_outs", {playing, valid, strobe, done, key}, 8'h00);
        chk("rst_mid_ram_port", {bus.read_or_write, bus.address, bus.key_input, bus.time_input}, 14'h2000);
      end
      tick();
    end
    rst = 1'b0; start = 1'b0; hw = 1'b0;
    chk("rst_mid_nowrite", n_wr - wr0, 0);
    chk("rst_mid_mem", {key_mem[1], time_mem[1]}, 8'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/music_score_player.md
Name: music_score_player

Overview:
- Sequencer that owns the music score RAM port.
- Plays the score by reading entries (Key, Time) in address order and holding each key for Time × TicksPerUnit clocks.
- Shares the RAM with a host loader: host writes are accepted only while the player is idle.
- Sits between the score RAM and the tone generator that consumes CurrentKey/NoteValid.

Parameters:
DataLength, 4, width of Key and Time fields
AddressBits, 5, score RAM address width
ScoreLength, 3, number of score entries played (1..2^AddressBits)
TicksPerUnit, 25000000, clocks per Time unit (≥2; benches use 4)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  pulse: begin playback from address 0
Stop  in  1  pulse: abort playback
Loop  in  1  level: wrap to address 0 after last entry
HostWrite  in  1  host write request (honoured only in IDLE)
HostAddress  in  AddressBits  host write address
HostKey  in  DataLength  host key data
HostTime  in  DataLength  host time data
ReadOrWrite  out  1  to RAM: 1=read, 0=write
Address  out  AddressBits  to RAM address
KeyInput  out  DataLength  to RAM key write data
TimeInput  out  DataLength  to RAM time write data
KeyOutput  in  DataLength  from RAM, registered, valid 1 clock after read address
TimeOutput  in  DataLength  from RAM, registered, valid 1 clock after read address
CurrentKey  out  DataLength  key being played
NoteValid  out  1  high while a note sounds
NoteStrobe  out  1  1-clock pulse on first PLAY cycle of each note
Playing  out  1  high in any state other than IDLE
Done  out  1  1-clock pulse at normal end of score

Behaviour:
- Reset is synchronous and active-high on Clock. All sequential state updates on the rising edge of Clock.
- Reset values: state IDLE, Address=0, ReadOrWrite=1, KeyInput=0, TimeInput=0, CurrentKey=0, NoteValid=0, NoteStrobe=0, Playing=0, Done=0, all counters 0.
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE:
  - ReadOrWrite=1 unless a write is in progress.
  - HostWrite=1 → same cycle, combinationally: ReadOrWrite=0, Address=HostAddress, KeyInput=HostKey, TimeInput=HostTime.
  - Start=1 (and Stop=0) → FETCH with Address=0.
  - HostWrite and Start in the same cycle: the write completes this cycle, then playback begins.
- FETCH: ReadOrWrite=1 with Address held; NoteValid=0 → WAIT.
- WAIT:
  - RAM data valid this cycle.
  - TimeOutput==0 is an end marker; handled as end-of-score (below).
  - Otherwise: CurrentKey←KeyOutput, latch Time, TickCount←0, UnitCount←1 → PLAY.
- PLAY:
  - NoteValid=1; NoteStrobe=1 on the first PLAY cycle only.
  - TickCount increments each clock and wraps at TicksPerUnit-1; UnitCount increments on each wrap.
  - Note ends on the cycle where UnitCount==latched Time and TickCount==TicksPerUnit-1.
  - Note length is therefore exactly Time×TicksPerUnit clocks. Time is unsigned, up to 2^DataLength-1.
- Note end:
  - Address<ScoreLength-1 → Address+1, FETCH.
  - Otherwise → end-of-score.
- End-of-score:
  - Loop=1 → Address=0, FETCH, no Done.
  - Loop=0 → Done=1 for one cycle (registered, coincident with entering IDLE), Address=0.
- CurrentKey holds its last value across FETCH/WAIT gaps and in IDLE. NoteValid=0 outside PLAY.
- Stop=1 in any non-IDLE state → IDLE next clock:
  - NoteValid=0, no Done, Address=0.
  - Stop wins over Start and over note end in the same cycle.
- Start while Playing: ignored.
- HostWrite while Playing: ignored. ReadOrWrite stays 1, so the RAM is never written during playback.
- Inter-note gap is fixed at 2 clocks (FETCH, WAIT).
- Reset mid-PLAY: next clock all outputs at reset values; the RAM is not written.

Test Plan:
1. TicksPerUnit=4, ScoreLength=3; host writes (0,1),(1,1),(0,1) in IDLE. Check ReadOrWrite=0 only during the 3 write cycles and that Address/KeyInput/TimeInput match the host inputs.
2. Start at cycle 0:
   - FETCH at 1, WAIT at 2, PLAY at 3–6 with NoteStrobe at 3 and CurrentKey=0.
   - Next note: PLAY 9–12 (key 1), then PLAY 15–18 (key 0).
   - Done pulse at cycle 19; Playing=0 from 19.
3. Score (2,3),(5,0): note key 2 lasts 12 clocks. Entry 1 is an end marker, so Done fires without sounding key 5 and NoteStrobe fires only once.
4. Loop=1 with the score from test 1: after the third note, Address returns to 0. NoteStrobe recurs every 6 clocks and Done never pulses.
5. Stop asserted on the 2nd PLAY cycle of note 1: NoteValid=0 and IDLE next clock, no Done. A Start asserted in the same cycle as Stop is ignored.
6. HostWrite during PLAY: RAM contents unchanged, verified by reading the score back. Reset mid-PLAY drives all outputs to reset values on the next clock.
